ub_read_sequencer: RTL

- Address and framing generator sitting directly upstream of the unified buffer read ports and the two streaming skewers.
- On a start command it streams num_tiles tiles of k_len rows each:
  - Per tile, the input address walks a fresh k_len-row block.
  - The weight address re-walks the same weight block (weight reuse).
- Drives first/last frame markers alongside each address and the skewer enable.
- Waits a fixed drain interval before signalling done, so results clear the skewers.

---
 rtl/ub_read_sequencer_pkg.sv | 16 +
 rtl/ub_read_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ub_read_sequencer_pkg.sv
// Shared types and constants for the unified-buffer read sequencer.
`ifndef ARRAY_SIZE
`define ARRAY_SIZE 4
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

package ub_read_sequencer_pkg;
  localparam int unsigned SEQ_ARRAY_SIZE    = `ARRAY_SIZE;
  localparam int unsigned SEQ_ADDR_WIDTH    = `ADDR_WIDTH;
  localparam int unsigned SEQ_LEN_WIDTH     = 16;
  localparam int unsigned SEQ_DEFAULT_DRAIN = 2 * `ARRAY_SIZE;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} seq_state_t;
endpackage

// File: rtl/ub_read_sequencer.sv
// Streams input/weight row addresses with first/last framing for num_tiles tiles,
// reusing the weight block per tile, then drains the skewers before pulsing done.
module ub_read_sequencer
  import ub_read_sequencer_pkg::*;
#(
  parameter int unsigned N            = SEQ_ARRAY_SIZE,
  parameter int unsigned ADDR_WIDTH   = SEQ_ADDR_WIDTH,
  parameter int unsigned LEN_WIDTH    = SEQ_LEN_WIDTH,
  parameter int unsigned DRAIN_CYCLES = 2 * N
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] input_base,
  input  logic [ADDR_WIDTH-1:0] weight_base,
  input  logic [LEN_WIDTH-1:0]  k_len,
  input  logic [LEN_WIDTH-1:0]  num_tiles,
  input  logic                  stall,
  output logic [ADDR_WIDTH-1:0] input_addr,
  output logic                  input_first_in,
  output logic                  input_last_in,
  output logic [ADDR_WIDTH-1:0] weight_addr,
  output logic                  weight_first_in,
  output logic                  weight_last_in,
  output logic                  rd_valid,
  output logic                  en,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  seq_state_t            r_state, w_state;
  logic [LEN_WIDTH-1:0]  r_row, w_row;
  logic [LEN_WIDTH-1:0]  r_tile, w_tile;
  logic [LEN_WIDTH-1:0]  r_k_len, w_k_len;
  logic [LEN_WIDTH-1:0]  r_num_tiles, w_num_tiles;
  logic [ADDR_WIDTH-1:0] r_wt_base, w_wt_base;
  logic [DRAIN_W-1:0]    r_drain_cnt, w_drain_cnt;
  logic [ADDR_WIDTH-1:0] w_in_addr, w_wt_addr;
  logic                  w_first, w_last, w_rd_valid, w_busy, w_done;
  logic                  w_last_row, w_last_tile;
  logic [LEN_WIDTH-1:0]  w_next_row;

  assign en = !stall;

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_row           <= '0;
      r_tile          <= '0;
      r_k_len         <= '0;
      r_num_tiles     <= '0;
      r_wt_base       <= '0;
      r_drain_cnt     <= '0;
      input_addr      <= '0;
      weight_addr     <= '0;
      input_first_in  <= 1'b0;
      input_last_in   <= 1'b0;
      weight_first_in <= 1'b0;
      weight_last_in  <= 1'b0;
      rd_valid        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      r_state         <= w_state;
      r_row           <= w_row;
      r_tile          <= w_tile;
      r_k_len         <= w_k_len;
      r_num_tiles     <= w_num_tiles;
      r_wt_base       <= w_wt_base;
      r_drain_cnt     <= w_drain_cnt;
      input_addr      <= w_in_addr;
      weight_addr     <= w_wt_addr;
      input_first_in  <= w_first;
      input_last_in   <= w_last;
      weight_first_in <= w_first;
      weight_last_in  <= w_last;
      rd_valid        <= w_rd_valid;
      busy            <= w_busy;
      done            <= w_done;
    end
  end

  assign w_last_row  = (r_row == r_k_len - LEN_WIDTH'(1));
  assign w_last_tile = (r_tile == r_num_tiles - LEN_WIDTH'(1));
  assign w_next_row  = r_row + LEN_WIDTH'(1);

  // Next-state and output logic; outputs always present the row currently held
  always_comb begin
    w_state     = r_state;
    w_row       = r_row;
    w_tile      = r_tile;
    w_k_len     = r_k_len;
    w_num_tiles = r_num_tiles;
    w_wt_base   = r_wt_base;
    w_drain_cnt = r_drain_cnt;
    w_in_addr   = input_addr;
    w_wt_addr   = weight_addr;
    w_first     = input_first_in;
    w_last      = input_last_in;
    w_rd_valid  = rd_valid;
    w_busy      = busy;
    w_done      = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_k_len     = k_len;
          w_num_tiles = num_tiles;
          w_wt_base   = weight_base;
          w_row       = '0;
          w_tile      = '0;
          if ((k_len == '0) || (num_tiles == '0)) begin
            w_state = DONE;
            w_done  = 1'b1;
          end else begin
            w_state    = STREAM;
            w_busy     = 1'b1;
            w_rd_valid = 1'b1;
            w_in_addr  = input_base;
            w_wt_addr  = weight_base;
            w_first    = 1'b1;
            w_last     = (k_len == LEN_WIDTH'(1));
          end
        end
      end
      STREAM: begin
        if (!stall) begin
          if (w_last_row && w_last_tile) begin
            w_state     = DRAIN;
            w_drain_cnt = '0;
            w_rd_valid  = 1'b0;
            w_in_addr   = '0;
            w_wt_addr   = '0;
            w_first     = 1'b0;
            w_last      = 1'b0;
          end else begin
            // Tiles are laid out back-to-back, so the input address simply increments
            w_in_addr = input_addr + ADDR_WIDTH'(1);
            if (w_last_row) begin
              w_row     = '0;
              w_tile    = r_tile + LEN_WIDTH'(1);
              w_wt_addr = r_wt_base;
              w_first   = 1'b1;
              w_last    = (r_k_len == LEN_WIDTH'(1));
            end else begin
              w_row     = w_next_row;
              w_wt_addr = weight_addr + ADDR_WIDTH'(1);
              w_first   = 1'b0;
              w_last    = (w_next_row == r_k_len - LEN_WIDTH'(1));
            end
          end
        end
      end
      DRAIN: begin
        if (!stall) begin
          if (r_drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
            w_state = DONE;
            w_busy  = 1'b0;
            w_done  = 1'b1;
          end else begin
            w_drain_cnt = r_drain_cnt + DRAIN_W'(1);
          end
        end
      end
      DONE: begin
        w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end

endmodule
